// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Purpose  : Instruction fetch stage: PC, imem req/ready handshake, one-entry
//            skid buffer, redirect drain and the IF/ID pipeline register.
//            Define IF_FETCH_CNT_EN to add fetch_cnt / flush_cnt counters.
// Revision : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        IFWrite,
    input  logic        Branch,
    input  logic        Jump,
    input  logic [31:0] JumpAddr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction_id,
    output logic [31:0] PC_id,
`ifdef IF_FETCH_CNT_EN
    output logic [31:0] fetch_cnt,
    output logic [31:0] flush_cnt,
`endif
    output logic        valid_id
);

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]  r_state,       w_state_nxt;
    logic [31:0] r_pc_if,       w_pc_if_nxt;
    logic [31:0] r_redirect_pc, w_redirect_pc_nxt;
    logic        r_buf_valid,   w_buf_valid_nxt;
    logic [31:0] r_buf_instr,   w_buf_instr_nxt;
    logic [31:0] r_buf_pc,      w_buf_pc_nxt;
    logic [31:0] r_instr_id,    w_instr_id_nxt;
    logic [31:0] r_pc_id,       w_pc_id_nxt;
    logic        r_valid_id,    w_valid_id_nxt;

    logic        w_done;
    logic        w_redir;

    assign imem_req       = (r_state != S_BOOT) && !r_buf_valid;
    assign imem_addr      = r_pc_if;
    assign w_done         = imem_req && imem_ready;
    assign w_redir        = Branch || Jump;
    assign Instruction_id = r_instr_id;
    assign PC_id          = r_pc_id;
    assign valid_id       = r_valid_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_BOOT;
            r_pc_if       <= RESET_PC;
            r_redirect_pc <= 32'h0;
            r_buf_valid   <= 1'b0;
            r_buf_instr   <= 32'h0;
            r_buf_pc      <= 32'h0;
            r_instr_id    <= NOP_INSTR;
            r_pc_id       <= 32'h0;
            r_valid_id    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc_if       <= w_pc_if_nxt;
            r_redirect_pc <= w_redirect_pc_nxt;
            r_buf_valid   <= w_buf_valid_nxt;
            r_buf_instr   <= w_buf_instr_nxt;
            r_buf_pc      <= w_buf_pc_nxt;
            r_instr_id    <= w_instr_id_nxt;
            r_pc_id       <= w_pc_id_nxt;
            r_valid_id    <= w_valid_id_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_if_nxt       = r_pc_if;
        w_redirect_pc_nxt = r_redirect_pc;
        w_buf_valid_nxt   = r_buf_valid;
        w_buf_instr_nxt   = r_buf_instr;
        w_buf_pc_nxt      = r_buf_pc;
        w_instr_id_nxt    = r_instr_id;
        w_pc_id_nxt       = r_pc_id;
        w_valid_id_nxt    = r_valid_id;

        case (r_state)
            S_BOOT: begin
                w_state_nxt    = S_FETCH;
                w_instr_id_nxt = NOP_INSTR;
                w_pc_id_nxt    = 32'h0;
                w_valid_id_nxt = 1'b0;
            end
            S_FETCH: begin
                if (!IFWrite) begin
                    // Redirect operands are stale during a load-use hold.
                    if (w_done) begin
                        w_buf_valid_nxt = 1'b1;
                        w_buf_instr_nxt = imem_rdata;
                        w_buf_pc_nxt    = r_pc_if;
                        w_pc_if_nxt     = r_pc_if + 32'd4;
                    end
                end else if (w_redir) begin
                    w_instr_id_nxt  = NOP_INSTR;
                    w_pc_id_nxt     = 32'h0;
                    w_valid_id_nxt  = 1'b0;
                    w_buf_valid_nxt = 1'b0;
                    if (w_done || !imem_req) begin
                        w_pc_if_nxt = JumpAddr;
                    end else begin
                        w_redirect_pc_nxt = JumpAddr;
                        w_state_nxt       = S_DRAIN;
                    end
                end else if (r_buf_valid) begin
                    w_instr_id_nxt  = r_buf_instr;
                    w_pc_id_nxt     = r_buf_pc;
                    w_valid_id_nxt  = 1'b1;
                    w_buf_valid_nxt = 1'b0;
                end else if (w_done) begin
                    w_instr_id_nxt = imem_rdata;
                    w_pc_id_nxt    = r_pc_if;
                    w_valid_id_nxt = 1'b1;
                    w_pc_if_nxt    = r_pc_if + 32'd4;
                end else begin
                    w_instr_id_nxt = NOP_INSTR;
                    w_pc_id_nxt    = 32'h0;
                    w_valid_id_nxt = 1'b0;
                end
            end
            S_DRAIN: begin
                w_instr_id_nxt = NOP_INSTR;
                w_pc_id_nxt    = 32'h0;
                w_valid_id_nxt = 1'b0;
                if (IFWrite && w_redir) begin
                    w_redirect_pc_nxt = JumpAddr;
                end
                // The newest target wins when a redirect lands on the ready cycle.
                if (imem_ready) begin
                    w_pc_if_nxt = (IFWrite && w_redir) ? JumpAddr : r_redirect_pc;
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

`ifdef IF_FETCH_CNT_EN
    logic        w_flush_evt;
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_flush_cnt;

    assign w_flush_evt = IFWrite && w_redir && (r_state != S_BOOT);
    assign fetch_cnt   = r_fetch_cnt;
    assign flush_cnt   = r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_cnt <= 32'h0;
            r_flush_cnt <= 32'h0;
        end else begin
            if (w_done) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_flush_evt) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
